// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - 5-stage MIPS pipeline sequencer: boot/run/redirect/halt FSM, load-use stalls, forwarding; optional perf counters under HAZARD_PERF_CNT_EN
module pipe_hazard_ctrl #(
  parameter int BOOT_CYCLES = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic [31:0]      dec_ir,
  input  logic [31:0]      ex_ir,
  input  logic [31:0]      mem_ir,
  input  logic [31:0]      wb_ir,
  input  logic             branch_taken,
  output logic             pc_en,
  output logic             pc_load,
  output logic             dec_en,
  output logic             dec_bubble,
  output logic             ex_bubble,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_HALT  = 6'b111111;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;

  localparam int            BW        = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_REDIR, S_HALT} state_e;

  function automatic logic f_is_alu(input logic [5:0] op, input logic [5:0] fn);
    return (op == OP_RTYPE) && ((fn == FN_ADD) || (fn == FN_SUB));
  endfunction

  function automatic logic f_reads_rs(input logic [5:0] op, input logic [5:0] fn);
    return f_is_alu(op, fn) || (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

  function automatic logic f_reads_rt(input logic [5:0] op, input logic [5:0] fn);
    return f_is_alu(op, fn) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

  state_e        state_q, state_d;
  logic [BW-1:0] boot_cnt_q, boot_cnt_d;
  logic          stall_hit, flush_hit;

  // Source/destination decode; j needs none since execute resolves it via branch_taken
  logic       dec_use_rs, dec_use_rt, ex_use_rs, ex_use_rt, ex_is_lw, ex_is_halt;
  logic       mem_fwd, wb_fwd, load_use;
  logic [4:0] mem_dst, wb_dst;

  assign dec_use_rs = f_reads_rs(dec_ir[31:26], dec_ir[5:0]);
  assign dec_use_rt = f_reads_rt(dec_ir[31:26], dec_ir[5:0]);
  assign ex_use_rs  = f_reads_rs(ex_ir[31:26], ex_ir[5:0]);
  assign ex_use_rt  = f_reads_rt(ex_ir[31:26], ex_ir[5:0]);
  assign ex_is_lw   = (ex_ir[31:26] == OP_LW);
  assign ex_is_halt = (ex_ir[31:26] == OP_HALT);

  assign mem_dst = (mem_ir[31:26] == OP_RTYPE) ? mem_ir[15:11] : mem_ir[20:16];
  assign wb_dst  = (wb_ir[31:26] == OP_RTYPE) ? wb_ir[15:11] : wb_ir[20:16];

  // A lw still in MEM has no data yet; the load-use stall guarantees it is in WB before use
  assign mem_fwd = (f_is_alu(mem_ir[31:26], mem_ir[5:0]) || (mem_ir[31:26] == OP_ADDI))
                   && (mem_dst != 5'd0);
  assign wb_fwd  = (f_is_alu(wb_ir[31:26], wb_ir[5:0]) || (wb_ir[31:26] == OP_ADDI)
                    || (wb_ir[31:26] == OP_LW)) && (wb_dst != 5'd0);

  assign load_use = ex_is_lw && (ex_ir[20:16] != 5'd0)
                    && ((dec_use_rs && (dec_ir[25:21] == ex_ir[20:16]))
                     || (dec_use_rt && (dec_ir[20:16] == ex_ir[20:16])));

  logic unused_bits;
  assign unused_bits = ^{dec_ir[15:6], ex_ir[15:6], mem_ir[25:21], mem_ir[10:6],
                         wb_ir[25:21], wb_ir[10:6]};

  // State register and boot-cycle counter
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_BOOT;
      boot_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
    end
  end

  // Next state and pipeline controls; reset forces the idle/bubble pattern
  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    pc_en      = 1'b0;
    pc_load    = 1'b0;
    dec_en     = 1'b0;
    dec_bubble = 1'b1;
    ex_bubble  = 1'b1;
    halted     = 1'b0;
    stall_hit  = 1'b0;
    flush_hit  = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_BOOT: begin
          pc_en = 1'b1;
          if (boot_cnt_q == BOOT_LAST) state_d = S_RUN;
          else boot_cnt_d = boot_cnt_q + BW'(1);
        end
        S_RUN: begin
          if (ex_is_halt) begin
            state_d = S_HALT;
          end else if (branch_taken) begin
            pc_load   = 1'b1;
            flush_hit = 1'b1;
            state_d   = S_REDIR;
          end else if (load_use) begin
            dec_bubble = 1'b0;
            stall_hit  = 1'b1;
          end else begin
            pc_en      = 1'b1;
            dec_en     = 1'b1;
            dec_bubble = 1'b0;
            ex_bubble  = 1'b0;
          end
        end
        S_REDIR: begin
          pc_en     = 1'b1;
          ex_bubble = 1'b0;
          state_d   = S_RUN;
        end
        S_HALT: begin
          dec_bubble = 1'b0;
          halted     = 1'b1;
        end
        default: state_d = S_BOOT;
      endcase
    end
  end

  // Operand forwarding for the instruction in execute; MEM beats WB
  always_comb begin
    fwd_a_sel = 2'd0;
    fwd_b_sel = 2'd0;
    if (rst_n && ex_use_rs) begin
      if (mem_fwd && (mem_dst == ex_ir[25:21])) fwd_a_sel = 2'd1;
      else if (wb_fwd && (wb_dst == ex_ir[25:21])) fwd_a_sel = 2'd2;
    end
    if (rst_n && ex_use_rt) begin
      if (mem_fwd && (mem_dst == ex_ir[20:16])) fwd_b_sel = 2'd1;
      else if (wb_fwd && (wb_dst == ex_ir[20:16])) fwd_b_sel = 2'd2;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  assign stall_cnt_d = (stall_hit && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  assign flush_cnt_d = (flush_hit && !(&flush_cnt_q)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;

  // Saturating event counters, cleared only by reset
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  logic unused_perf;
  assign unused_perf = stall_hit ^ flush_hit;
  assign stall_cnt   = '0;
  assign flush_cnt   = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] dec_ir = '0, ex_ir = '0, mem_ir = '0, wb_ir = '0;
  logic        branch_taken = 1'b0;
  logic        pc_en, pc_load, dec_en, dec_bubble, ex_bubble, halted;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [15:0] stall_cnt, flush_cnt;

  int checks = 0;
  int failures = 0;
  logic [9:0] exp_q[$];

  pipe_hazard_ctrl #(.BOOT_CYCLES(1), .CNT_W(16)) dut (
    .clock(clock), .rst_n(rst_n), .dec_ir(dec_ir), .ex_ir(ex_ir), .mem_ir(mem_ir),
    .wb_ir(wb_ir), .branch_taken(branch_taken), .pc_en(pc_en), .pc_load(pc_load),
    .dec_en(dec_en), .dec_bubble(dec_bubble), .ex_bubble(ex_bubble),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clock = ~clock;

  wire [9:0] obs = {pc_en, pc_load, dec_en, dec_bubble, ex_bubble, fwd_a_sel, fwd_b_sel, halted};

  function automatic logic [9:0] ev(input logic pe, pl, de, db, eb, input logic [1:0] fa, fb,
                                    input logic h);
    return {pe, pl, de, db, eb, fa, fb, h};
  endfunction

  function automatic logic [31:0] r_ins(input logic [5:0] fn, input logic [4:0] rd, rs, rt);
    return {6'b000000, rs, rt, rd, 5'b00000, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rt, rs,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B, OP_BEQ = 6'h04;

  task automatic drive(input logic [31:0] d, e, m, w, input logic b);
    @(posedge clock);
    #1;
    dec_ir = d; ex_ir = e; mem_ir = m; wb_ir = w; branch_taken = b;
  endtask

  task automatic test_reset();
    logic [9:0] want;
    dec_ir = r_ins(FN_ADD, 3, 2, 4); ex_ir = i_ins(OP_LW, 2, 1, 0);
    mem_ir = r_ins(FN_ADD, 1, 5, 5); wb_ir = '0; branch_taken = 1'b1;
    #3;
    exp_q.push_back(ev(0, 0, 0, 1, 1, 0, 0, 0));
    want = exp_q.pop_front(); checks++;
    if (obs !== want) begin failures++; $display("FAIL reset_outputs got=%b want=%b", obs, want); end
    checks++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      failures++; $display("FAIL reset_counters got=%0d/%0d want=0/0", stall_cnt, flush_cnt);
    end
    @(posedge clock); #1;
    rst_n = 1'b1; dec_ir = '0; ex_ir = '0; mem_ir = '0; wb_ir = '0; branch_taken = 1'b0;
    exp_q.push_back(ev(1, 0, 0, 1, 1, 0, 0, 0));
    @(negedge clock);
    want = exp_q.pop_front(); checks++;
    if (obs !== want) begin failures++; $display("FAIL boot_cycle got=%b want=%b", obs, want); end
    drive('0, '0, '0, '0, 1'b0);
    exp_q.push_back(ev(1, 0, 1, 0, 0, 0, 0, 0));
    @(negedge clock);
    want = exp_q.pop_front(); checks++;
    if (obs !== want) begin failures++; $display("FAIL first_run got=%b want=%b", obs, want); end
  endtask

  task automatic test_load_use();
    logic [31:0] d[3], e[3], m[3], w[3];
    logic [9:0] x[3];
    logic [9:0] want;
    d = '{r_ins(FN_ADD, 3, 2, 4), r_ins(FN_ADD, 3, 2, 4), 32'h0};
    e = '{i_ins(OP_LW, 2, 1, 0), 32'h0, r_ins(FN_ADD, 3, 2, 4)};
    m = '{32'h0, i_ins(OP_LW, 2, 1, 0), 32'h0};
    w = '{32'h0, 32'h0, i_ins(OP_LW, 2, 1, 0)};
    x = '{ev(0, 0, 0, 0, 1, 0, 0, 0), ev(1, 0, 1, 0, 0, 0, 0, 0), ev(1, 0, 1, 0, 0, 2, 0, 0)};
    for (int i = 0; i < 3; i++) begin
      drive(d[i], e[i], m[i], w[i], 1'b0);
      exp_q.push_back(x[i]);
      @(negedge clock);
      want = exp_q.pop_front(); checks++;
      if (obs !== want) begin failures++; $display("FAIL load_use[%0d] got=%b want=%b", i, obs, want); end
    end
    checks++;
    if (stall_cnt !== 16'(PERF)) begin
      failures++; $display("FAIL stall_cnt_after_lu got=%0d want=%0d", stall_cnt, PERF);
    end
  endtask

  task automatic test_forwarding();
    logic [31:0] e[5], m[5], w[5];
    logic [9:0] x[5];
    logic [9:0] want;
    e = '{r_ins(FN_SUB, 6, 5, 5), r_ins(FN_SUB, 6, 5, 5), r_ins(FN_SUB, 6, 5, 7),
          i_ins(OP_SW, 5, 7, 4), i_ins(OP_ADDI, 9, 5, 1)};
    m = '{i_ins(OP_ADDI, 5, 0, 7), 32'h0, i_ins(OP_LW, 5, 1, 0),
          r_ins(FN_ADD, 7, 1, 1), r_ins(FN_ADD, 9, 1, 1)};
    w = '{r_ins(FN_ADD, 5, 1, 1), r_ins(FN_ADD, 5, 1, 1), 32'h0,
          i_ins(OP_LW, 5, 1, 0), r_ins(FN_ADD, 5, 1, 1)};
    x = '{ev(1, 0, 1, 0, 0, 1, 1, 0), ev(1, 0, 1, 0, 0, 2, 2, 0), ev(1, 0, 1, 0, 0, 0, 0, 0),
          ev(1, 0, 1, 0, 0, 1, 2, 0), ev(1, 0, 1, 0, 0, 2, 0, 0)};
    for (int i = 0; i < 5; i++) begin
      drive('0, e[i], m[i], w[i], 1'b0);
      exp_q.push_back(x[i]);
      @(negedge clock);
      want = exp_q.pop_front(); checks++;
      if (obs !== want) begin failures++; $display("FAIL forwarding[%0d] got=%b want=%b", i, obs, want); end
    end
  endtask

  task automatic test_branch();
    logic [31:0] d[6], e[6], m[6];
    logic        b[6];
    logic [9:0]  x[6];
    logic [9:0]  want;
    d = '{r_ins(FN_ADD, 3, 2, 4), r_ins(FN_ADD, 3, 2, 4), 32'h0, 32'h0, 32'h0, 32'h0};
    e = '{i_ins(OP_LW, 2, 1, 0), 32'h0, 32'h0, i_ins(OP_BEQ, 2, 1, 0), 32'h0, 32'h0};
    m = '{32'h0, 32'h0, 32'h0, r_ins(FN_ADD, 1, 3, 3), 32'h0, 32'h0};
    b = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    x = '{ev(0, 1, 0, 1, 1, 0, 0, 0), ev(1, 0, 0, 1, 0, 0, 0, 0), ev(1, 0, 1, 0, 0, 0, 0, 0),
          ev(0, 1, 0, 1, 1, 1, 0, 0), ev(1, 0, 0, 1, 0, 0, 0, 0), ev(1, 0, 1, 0, 0, 0, 0, 0)};
    for (int i = 0; i < 6; i++) begin
      drive(d[i], e[i], m[i], '0, b[i]);
      exp_q.push_back(x[i]);
      @(negedge clock);
      want = exp_q.pop_front(); checks++;
      if (obs !== want) begin failures++; $display("FAIL branch[%0d] got=%b want=%b", i, obs, want); end
    end
    checks++;
    if (flush_cnt !== 16'(2 * PERF) || stall_cnt !== 16'(PERF)) begin
      failures++;
      $display("FAIL perf_after_branch got=%0d/%0d want=%0d/%0d", flush_cnt, stall_cnt, 2 * PERF, PERF);
    end
  endtask

  task automatic test_reset_mid_redirect();
    logic [9:0] want;
    drive('0, '0, '0, '0, 1'b1);
    exp_q.push_back(ev(0, 1, 0, 1, 1, 0, 0, 0));
    @(negedge clock);
    want = exp_q.pop_front(); checks++;
    if (obs !== want) begin failures++; $display("FAIL redir_flush got=%b want=%b", obs, want); end
    @(posedge clock); #1;
    branch_taken = 1'b0; rst_n = 1'b0;
    #1;
    exp_q.push_back(ev(0, 0, 0, 1, 1, 0, 0, 0));
    want = exp_q.pop_front(); checks++;
    if (obs !== want) begin failures++; $display("FAIL redir_reset got=%b want=%b", obs, want); end
    checks++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      failures++; $display("FAIL redir_reset_counters got=%0d/%0d want=0/0", stall_cnt, flush_cnt);
    end
    @(posedge clock); #1;
    rst_n = 1'b1;
    exp_q.push_back(ev(1, 0, 0, 1, 1, 0, 0, 0));
    @(negedge clock);
    want = exp_q.pop_front(); checks++;
    if (obs !== want) begin failures++; $display("FAIL redir_reboot got=%b want=%b", obs, want); end
    drive('0, '0, '0, '0, 1'b0);
    exp_q.push_back(ev(1, 0, 1, 0, 0, 0, 0, 0));
    @(negedge clock);
    want = exp_q.pop_front(); checks++;
    if (obs !== want) begin failures++; $display("FAIL redir_discarded got=%b want=%b", obs, want); end
  endtask

  task automatic test_zero_reg();
    logic [31:0] d[3], e[3], m[3], w[3];
    logic [9:0] want;
    d = '{r_ins(FN_ADD, 3, 0, 0), 32'h0, 32'h0};
    e = '{i_ins(OP_LW, 0, 1, 0), r_ins(FN_ADD, 7, 0, 0), r_ins(FN_ADD, 7, 0, 0)};
    m = '{32'h0, i_ins(OP_ADDI, 0, 1, 3), 32'h0};
    w = '{32'h0, r_ins(FN_ADD, 0, 1, 1), i_ins(OP_LW, 0, 1, 0)};
    for (int i = 0; i < 3; i++) begin
      drive(d[i], e[i], m[i], w[i], 1'b0);
      exp_q.push_back(ev(1, 0, 1, 0, 0, 0, 0, 0));
      @(negedge clock);
      want = exp_q.pop_front(); checks++;
      if (obs !== want) begin failures++; $display("FAIL zero_reg[%0d] got=%b want=%b", i, obs, want); end
    end
    checks++;
    if (stall_cnt !== 16'd0) begin failures++; $display("FAIL zero_reg_stall got=%0d want=0", stall_cnt); end
  endtask

  task automatic test_halt();
    logic [9:0] want;
    drive(r_ins(FN_ADD, 3, 2, 4), 32'hFC000000, '0, '0, 1'b0);
    exp_q.push_back(ev(0, 0, 0, 1, 1, 0, 0, 0));
    @(negedge clock);
    want = exp_q.pop_front(); checks++;
    if (obs !== want) begin failures++; $display("FAIL halt_enter got=%b want=%b", obs, want); end
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 1) drive(r_ins(FN_ADD, 3, 2, 4), i_ins(OP_LW, 2, 1, 0), '0, '0, 1'b1);
      else drive('0, '0, '0, '0, 1'b0);
      exp_q.push_back(ev(0, 0, 0, 0, 1, 0, 0, 1));
      @(negedge clock);
      want = exp_q.pop_front(); checks++;
      if (obs !== want) begin failures++; $display("FAIL halted[%0d] got=%b want=%b", i, obs, want); end
    end
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(ev(0, 0, 0, 1, 1, 0, 0, 0));
    want = exp_q.pop_front(); checks++;
    if (obs !== want) begin failures++; $display("FAIL halt_async_reset got=%b want=%b", obs, want); end
    @(posedge clock); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_use();
    test_forwarding();
    test_branch();
    test_reset_mid_redirect();
    test_zero_reg();
    test_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
